writeback: RTL and testbench

Final pipeline stage and register-file owner. Consumes the `stage_status_t` bundle produced by `memory_access` and commits `data.value` to the 32×32-bit integer register file. Provides two combinational read ports with write-through bypass to decode. Maintains a retired-instruction counter, a cycle counter and the PC of the last retired instruction.

---
 rtl/writeback.sv | 146 ++++++++++++++
 tb/tb_writeback.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback.sv
// Final pipeline stage: commits results into the 32x32 register file and
// keeps the retirement counters.
// Latency: writes land at the next rising edge, read ports are combinational
// with a same-cycle write-through bypass, and counters update one edge later.
// Backpressure: none. ready is tied high because writeback never stalls.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   stage_in            result bundle from memory_access (valid, pc, data)
//   reg_a_1/reg_a_2     read indices from decode
//   reg_rd1/reg_rd2     read data (x0 reads 0, bypass on same-cycle commit)
//   ready               constant 1
//   retired_count       instructions retired since reset (wraps)
//   cycle_count         clock edges since reset release (wraps)
//   last_pc/last_valid  pc of the most recent retirement, and whether one has happened

package writeback_pkg;

  typedef struct packed {
    logic        valid;   // instruction has a destination register
    logic [4:0]  target;  // destination register index
    logic [31:0] value;   // result to commit
  } wb_data_t;

  typedef struct packed {
    logic        valid;   // an instruction retires this cycle
    logic [31:0] pc;
    logic [31:0] instr;   // carried for debug, not used here
    wb_data_t    data;
  } stage_status_t;

endpackage

module writeback
  import writeback_pkg::*;
#(
  parameter int COUNTER_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  stage_status_t            stage_in,
  input  logic [4:0]               reg_a_1,
  input  logic [4:0]               reg_a_2,
  output logic [31:0]              reg_rd1,
  output logic [31:0]              reg_rd2,
  output logic                     ready,
  output logic [COUNTER_WIDTH-1:0] retired_count,
  output logic [COUNTER_WIDTH-1:0] cycle_count,
  output logic [31:0]              last_pc,
  output logic                     last_valid
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

  // x0 is never stored.
  logic [31:0] regs_q [1:31];
  logic [31:0] regs_d [1:31];

  logic [COUNTER_WIDTH-1:0] retired_q, retired_d;
  logic [COUNTER_WIDTH-1:0] cycle_q,   cycle_d;
  logic [31:0]              last_pc_q, last_pc_d;
  logic                     last_valid_q, last_valid_d;

  logic commit;
  logic retire;

  // The instruction word is carried only for debug and is not consumed here.
  logic unused_instr;
  assign unused_instr = ^stage_in.instr;

  // Qualifying with rst_n keeps the bypass dead while reset is held, so the
  // read ports show the cleared storage instead of an in-flight result.
  assign commit = rst_n && stage_in.valid && stage_in.data.valid &&
                  (stage_in.data.target != 5'd0);
  assign retire = stage_in.valid;

  assign ready = 1'b1;

  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < 32; i++) begin
      if (commit && (stage_in.data.target == 5'(i))) begin
        regs_d[i] = stage_in.data.value;
      end
    end
  end

  always_comb begin
    retired_d    = retired_q;
    last_pc_d    = last_pc_q;
    last_valid_d = last_valid_q;
    cycle_d      = cycle_q + CNT_ONE;
    if (retire) begin
      retired_d    = retired_q + CNT_ONE;
      last_pc_d    = stage_in.pc;
      last_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      retired_q    <= '0;
      cycle_q      <= '0;
      last_pc_q    <= '0;
      last_valid_q <= 1'b0;
    end else begin
      regs_q       <= regs_d;
      retired_q    <= retired_d;
      cycle_q      <= cycle_d;
      last_pc_q    <= last_pc_d;
      last_valid_q <= last_valid_d;
    end
  end

  // Read ports: x0 first, then the same-cycle bypass, then storage.
  always_comb begin
    reg_rd1 = '0;
    if (reg_a_1 != 5'd0) begin
      if (commit && (stage_in.data.target == reg_a_1)) begin
        reg_rd1 = stage_in.data.value;
      end else begin
        reg_rd1 = regs_q[reg_a_1];
      end
    end
  end

  always_comb begin
    reg_rd2 = '0;
    if (reg_a_2 != 5'd0) begin
      if (commit && (stage_in.data.target == reg_a_2)) begin
        reg_rd2 = stage_in.data.value;
      end else begin
        reg_rd2 = regs_q[reg_a_2];
      end
    end
  end

  assign retired_count = retired_q;
  assign cycle_count   = cycle_q;
  assign last_pc       = last_pc_q;
  assign last_valid    = last_valid_q;

endmodule

// File: tb/tb_writeback.sv
// Bench for writeback: a 64-bit-counter instance and a 4-bit-counter instance
// share all stimulus; expected reg_rd1 values go through a scoreboard queue.
// Inputs change 1ns after a rising edge and outputs are sampled on the falling edge.

module tb_writeback;
  import writeback_pkg::*;

  logic          clk;
  logic          rst_n;
  stage_status_t stage_in;
  logic [4:0]    reg_a_1;
  logic [4:0]    reg_a_2;

  logic [31:0] reg_rd1, reg_rd2, last_pc;
  logic        ready, last_valid;
  logic [63:0] retired_count, cycle_count;

  logic [31:0] w_rd1, w_rd2, w_last_pc;
  logic        w_ready, w_last_valid;
  logic [3:0]  w_retired, w_cycle;

  int tests_run = 0;
  int fails     = 0;

  logic [31:0] sb_q[$];

  writeback #(.COUNTER_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .stage_in(stage_in),
    .reg_a_1(reg_a_1), .reg_a_2(reg_a_2),
    .reg_rd1(reg_rd1), .reg_rd2(reg_rd2), .ready(ready),
    .retired_count(retired_count), .cycle_count(cycle_count),
    .last_pc(last_pc), .last_valid(last_valid)
  );

  writeback #(.COUNTER_WIDTH(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .stage_in(stage_in),
    .reg_a_1(reg_a_1), .reg_a_2(reg_a_2),
    .reg_rd1(w_rd1), .reg_rd2(w_rd2), .ready(w_ready),
    .retired_count(w_retired), .cycle_count(w_cycle),
    .last_pc(w_last_pc), .last_valid(w_last_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (time %0t, limit 200000)", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input logic v, input logic dv, input logic [4:0] tgt,
                       input logic [31:0] val, input logic [31:0] pc);
    stage_in.valid       = v;
    stage_in.pc          = pc;
    stage_in.instr       = 32'h0000_0013;
    stage_in.data.valid  = dv;
    stage_in.data.target = tgt;
    stage_in.data.value  = val;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges, hold it across one edge, release between edges.
  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    rst_n = 1'b0;
    idle();
    reg_a_1 = 5'd1;
    reg_a_2 = 5'd2;
    #2;
    tests_run++;
    if (reg_rd1 !== 32'h0 || reg_rd2 !== 32'h0) begin
      fails++; $display("FAIL reset_reads: rd1=%h rd2=%h want 0/0", reg_rd1, reg_rd2);
    end
    tests_run++;
    if (retired_count !== 64'd0 || cycle_count !== 64'd0 || last_pc !== 32'h0 || last_valid !== 1'b0) begin
      fails++; $display("FAIL reset_state: ret=%0d cyc=%0d pc=%h lv=%b want 0/0/0/0",
                        retired_count, cycle_count, last_pc, last_valid);
    end
    tests_run++;
    if (ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready: ready=%b want 1", ready);
    end
    step();
    rst_n = 1'b1;
    // Bench-side expectation: after rst_n rises between edges, the first edge makes cycle_count 1.
    step();
    tests_run++;
    if (cycle_count !== 64'd1) begin
      fails++; $display("FAIL first_cycle: cycle_count=%0d want 1", cycle_count);
    end
    exp = 32'h0;
    sb_q.push_back(exp);
  endtask

  task automatic test_write_bypass();
    logic [31:0] exp;
    // Consume the reset-state expectation (x1 reads 0 after reset).
    @(negedge clk);
    exp = sb_q.pop_front();
    tests_run++;
    if (reg_rd1 !== exp) begin
      fails++; $display("FAIL post_reset_read: rd1=%h want %h", reg_rd1, exp);
    end
    step();
    drive(1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 32'h40);
    reg_a_1 = 5'd7;
    reg_a_2 = 5'd7;
    sb_q.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    exp = sb_q.pop_front();
    tests_run++;
    if (reg_rd1 !== exp || reg_rd2 !== exp) begin
      fails++; $display("FAIL bypass_same_cycle: rd1=%h rd2=%h want %h", reg_rd1, reg_rd2, exp);
    end
    step();
    idle();
    sb_q.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    exp = sb_q.pop_front();
    tests_run++;
    if (reg_rd1 !== exp) begin
      fails++; $display("FAIL stored_next_cycle: rd1=%h want %h", reg_rd1, exp);
    end
    // A new commit to x7 must win over the stored value in the same cycle.
    step();
    drive(1'b1, 1'b1, 5'd7, 32'h1111_2222, 32'h44);
    reg_a_2 = 5'd1;
    sb_q.push_back(32'h1111_2222);
    @(negedge clk);
    exp = sb_q.pop_front();
    tests_run++;
    if (reg_rd1 !== exp || reg_rd2 !== 32'h0) begin
      fails++; $display("FAIL bypass_override: rd1=%h rd2=%h want %h/0", reg_rd1, reg_rd2, exp);
    end
    step();
    idle();
  endtask

  task automatic test_x0();
    logic [63:0] ret_before;
    logic [31:0] exp;
    ret_before = retired_count;
    drive(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h80);
    reg_a_1 = 5'd0;
    reg_a_2 = 5'd0;
    sb_q.push_back(32'h0);
    @(negedge clk);
    exp = sb_q.pop_front();
    tests_run++;
    if (reg_rd1 !== exp || reg_rd2 !== 32'h0) begin
      fails++; $display("FAIL x0_same_cycle: rd1=%h rd2=%h want 0/0", reg_rd1, reg_rd2);
    end
    step();
    idle();
    sb_q.push_back(32'h0);
    @(negedge clk);
    exp = sb_q.pop_front();
    tests_run++;
    if (reg_rd1 !== exp || reg_rd2 !== 32'h0) begin
      fails++; $display("FAIL x0_next_cycle: rd1=%h rd2=%h want 0/0", reg_rd1, reg_rd2);
    end
    tests_run++;
    if (retired_count !== ret_before + 64'd1) begin
      fails++; $display("FAIL x0_retire: retired=%0d want %0d", retired_count, ret_before + 64'd1);
    end
    step();
  endtask

  task automatic test_store();
    logic [63:0] ret_before;
    logic [31:0] exp;
    drive(1'b1, 1'b1, 5'd3, 32'h0000_0033, 32'hF0);
    step();
    ret_before = retired_count;
    drive(1'b1, 1'b0, 5'd3, 32'h0000_0BAD, 32'h100);
    reg_a_1 = 5'd3;
    sb_q.push_back(32'h0000_0033);
    @(negedge clk);
    exp = sb_q.pop_front();
    tests_run++;
    if (reg_rd1 !== exp) begin
      fails++; $display("FAIL store_no_bypass: rd1=%h want %h", reg_rd1, exp);
    end
    step();
    idle();
    sb_q.push_back(32'h0000_0033);
    @(negedge clk);
    exp = sb_q.pop_front();
    tests_run++;
    if (reg_rd1 !== exp) begin
      fails++; $display("FAIL store_no_write: rd1=%h want %h", reg_rd1, exp);
    end
    tests_run++;
    if (retired_count !== ret_before + 64'd1 || last_pc !== 32'h100 || last_valid !== 1'b1) begin
      fails++; $display("FAIL store_retire: ret=%0d pc=%h lv=%b want %0d/00000100/1",
                        retired_count, last_pc, last_valid, ret_before + 64'd1);
    end
    step();
  endtask

  task automatic test_counters();
    do_reset();
    drive(1'b1, 1'b1, 5'd10, 32'hA0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step();
      if (i + 1 < 4) drive(1'b1, 1'b1, 5'(10 + i + 1), 32'hA0 + 32'(i + 1), 32'(4 * (i + 1)));
      else idle();
    end
    tests_run++;
    if (cycle_count !== 64'd10) begin
      fails++; $display("FAIL counters_cycle: cycle_count=%0d want 10", cycle_count);
    end
    tests_run++;
    if (retired_count !== 64'd4 || last_pc !== 32'hC) begin
      fails++; $display("FAIL counters_retire: retired=%0d last_pc=%h want 4/0000000c", retired_count, last_pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 5'd0, 32'h0, 32'(i * 4));
      step();
      if (i == 14) begin
        tests_run++;
        if (w_retired !== 4'd15) begin
          fails++; $display("FAIL wrap_pre: retired=%0d want 15", w_retired);
        end
      end
    end
    idle();
    tests_run++;
    if (w_retired !== 4'd0 || retired_count !== 64'd16) begin
      fails++; $display("FAIL wrap: small=%0d big=%0d want 0/16", w_retired, retired_count);
    end
    tests_run++;
    if (w_cycle !== 4'd0 || w_last_pc !== 32'h3C) begin
      fails++; $display("FAIL wrap_cycle: cycle=%0d last_pc=%h want 0/0000003c", w_cycle, w_last_pc);
    end
  endtask

  task automatic test_reset_async();
    logic [31:0] exp;
    drive(1'b1, 1'b1, 5'd5, 32'h0000_1234, 32'h200);
    step();
    idle();
    reg_a_1 = 5'd5;
    sb_q.push_back(32'h0000_1234);
    @(negedge clk);
    exp = sb_q.pop_front();
    tests_run++;
    if (reg_rd1 !== exp) begin
      fails++; $display("FAIL x5_before_reset: rd1=%h want %h", reg_rd1, exp);
    end
    // Assert reset mid-cycle with a commit to x5 on the inputs.
    #2;
    drive(1'b1, 1'b1, 5'd5, 32'h5555_5555, 32'h204);
    rst_n = 1'b0;
    #1;
    sb_q.push_back(32'h0);
    exp = sb_q.pop_front();
    tests_run++;
    if (reg_rd1 !== exp) begin
      fails++; $display("FAIL async_reset_read: rd1=%h want %h", reg_rd1, exp);
    end
    tests_run++;
    if (retired_count !== 64'd0 || cycle_count !== 64'd0 || last_valid !== 1'b0) begin
      fails++; $display("FAIL async_reset_state: ret=%0d cyc=%0d lv=%b want 0/0/0",
                        retired_count, cycle_count, last_valid);
    end
    step();
    idle();
    rst_n = 1'b1;
    sb_q.push_back(32'h0);
    @(negedge clk);
    exp = sb_q.pop_front();
    tests_run++;
    if (reg_rd1 !== exp) begin
      fails++; $display("FAIL write_lost_in_reset: rd1=%h want %h", reg_rd1, exp);
    end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_x0();
    test_store();
    test_counters();
    test_wrap();
    test_reset_async();
    tests_run++;
    if (sb_q.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
